fifo_ptr_mc: RTL and testbench
==============================

// Module: fifo_ptr_mc
// PURPOSE
//  Multi-channel pointer FIFO: C independent FIFOs of N entries of W bits each, in one flop array.
//  Per-channel speculative read pointer with commit/replay, plus per-channel flush.
//  Sits between a shared producer and a speculative consumer (e.g. issue/retry queues).
//  At most one push, one pop, one commit and one replay per cycle, each tagged with a channel id.
// PARAMETERS
//  W           32  data width in bits
//  N           16  entries per channel; power of two, >=2
//  C           4   channel count, >=1; IDW = max(1,$clog2(C))
//  HAS_REPLAY  0   1: pop advances spec ptr; commit advances arch ptr; replay rewinds spec ptr
//  HAS_FLUSH   0   1: flush input honoured; 0: flush ignored
// PORTS
//  clk          in   1      clock
//  rst          in   1      reset; synchronous, active-high
//  push         in   1      write push_data to channel push_id
//  push_id      in   IDW    push channel
//  push_data    in   W      push payload
//  pop          in   1      read head of channel pop_id
//  pop_id       in   IDW    pop channel
//  pop_vld_r    out  1      pop_data valid; registered, 1 cycle after accepted pop
//  pop_data_r   out  W      popped payload
//  commit       in   1      retire oldest popped entry of commit_id (HAS_REPLAY only)
//  commit_id    in   IDW    commit channel
//  replay       in   1      rewind spec ptr of replay_id to arch ptr (HAS_REPLAY only)
//  replay_id    in   IDW    replay channel
//  flush        in   C      per-channel flush (HAS_FLUSH only)
//  empty_r      out  C      per-channel empty, registered
//  full_r       out  C      per-channel full, registered
//  err_r        out  1      1-cycle pulse: a request was dropped (push-full/pop-empty/bad commit)
// BEHAVIOUR
//  - Pointers: PTR = $clog2(N)+1 bits per channel (wptr, arch_rptr, spec_rptr); wrap mod 2N.
//  - HAS_REPLAY=0: spec_rptr aliases arch_rptr; commit and replay ignored, never raise err_r.
//  - Reset: all ptrs 0; empty_r all 1; full_r 0; pop_vld_r 0; pop_data_r 0; err_r 0.
//  - empty[c] = spec_rptr==wptr. full[c] = low bits equal and MSBs differ (wptr vs arch_rptr).
//  - Status outputs are registered: they reflect post-update pointers the cycle after an event.
//  - Accept checks use the registered status of the addressed channel:
//      push accepted iff !full_r[push_id]; else dropped, err_r next cycle.
//      pop accepted iff !empty_r[pop_id]; else dropped, err_r next cycle.
//  - An accepted push writes mem[push_id][wptr] and increments wptr.
//  - An accepted pop reads mem[pop_id][spec_rptr] and increments spec_rptr.
//    pop_vld_r=1 next cycle with that data. Otherwise pop_vld_r=0 and pop_data_r holds.
//  - Commit: accepted iff arch_rptr!=spec_rptr on commit_id; increments arch_rptr.
//    Else dropped and err_r pulses.
//  - Replay: spec_rptr <= arch_rptr on replay_id.
//    A same-cycle pop on the same channel is dropped without error; replay wins.
//  - Same-cycle replay + commit on the same channel: spec_rptr <= arch_rptr+1 (committed entry stays retired).
//  - Push and pop on the same channel in one cycle:
//    both are legal when neither status blocks them. Push-to-empty is not poppable until empty_r falls.
//  - Pop/commit on a full channel frees space from the cycle after full_r deasserts (no bypass).
//  - Flush[c] (HAS_FLUSH=1): all three ptrs of c <= 0.
//    Overrides every same-cycle push/pop/commit/replay to c without error.
//    empty_r[c]=1 and full_r[c]=0 next cycle. Other channels are unaffected.
//  - Reset mid-operation: all state returns to reset values next cycle. In-flight pop_vld_r is cancelled.
//  - Requests to different channels in the same cycle are fully independent.
//  - pop_id/push_id >= C: request dropped, err_r pulses.
// TESTING
//  1. C=4,N=4: push 4 to ch2 (0xA0..A3) -> full_r[2]=1, others empty.
//     5th push -> err_r=1, wptr unchanged.
//  2. Pop ch2 x4 -> pop_vld_r each next cycle with A0..A3.
//     Then empty_r[2]=1; 5th pop -> err_r=1, pop_vld_r=0.
//  3. HAS_REPLAY=1: push B0..B2 ch1, pop x2, replay ch1 -> next pops return B0,B1,B2.
//     commit x1 then replay -> pops return B1.
//  4. Wrap: N=4, 10 push/pop/commit rounds on ch0 -> data order preserved.
//     full_r only when 4 uncommitted.
//  5. Same cycle: flush[3] + push ch3 + pop ch0 -> ch3 empty, no err_r.
//     ch0 pop completes normally.
//  6. Reset asserted the cycle after a pop -> pop_vld_r=0, all empty_r=1, full_r=0.

Source files
------------

// File: rtl/fifo_ptr_mc.sv
// C independent N-deep FIFOs sharing one flop array, with a per-channel speculative
// read pointer (commit/replay) and per-channel flush. All status outputs are registered.
module fifo_ptr_mc #(
    parameter int W          = 32,
    parameter int N          = 16,
    parameter int C          = 4,
    parameter int HAS_REPLAY = 0,
    parameter int HAS_FLUSH  = 0,
    parameter int IDW        = (C > 1) ? $clog2(C) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic [IDW-1:0] push_id,
    input  logic [W-1:0]   push_data,
    input  logic           pop,
    input  logic [IDW-1:0] pop_id,
    output logic           pop_vld_r,
    output logic [W-1:0]   pop_data_r,
    input  logic           commit,
    input  logic [IDW-1:0] commit_id,
    input  logic           replay,
    input  logic [IDW-1:0] replay_id,
    input  logic [C-1:0]   flush,
    output logic [C-1:0]   empty_r,
    output logic [C-1:0]   full_r,
    output logic           err_r
);

    localparam int PTR = $clog2(N) + 1;
    localparam int AW  = PTR - 1;

    typedef logic [PTR-1:0] ptr_t;

    logic [W-1:0] mem [C][N];

    ptr_t wptr_reg      [C];
    ptr_t arch_rptr_reg [C];
    ptr_t spec_rptr_reg [C];
    ptr_t wptr_next     [C];
    ptr_t arch_rptr_next[C];
    ptr_t spec_rptr_next[C];
    ptr_t arch_inc      [C];
    ptr_t spec_adv      [C];

    logic [C-1:0] flush_eff;
    logic [C-1:0] push_hit;
    logic [C-1:0] pop_hit;
    logic [C-1:0] commit_hit;
    logic [C-1:0] replay_hit;
    logic [C-1:0] empty_next;
    logic [C-1:0] full_next;

    logic replay_en;
    logic commit_en;
    logic push_id_ok;
    logic pop_id_ok;
    logic commit_id_ok;
    logic replay_id_ok;
    logic push_flushed;
    logic pop_blocked;
    logic commit_flushed;
    logic push_ok;
    logic pop_ok;
    logic commit_ok;
    logic push_err;
    logic pop_err;
    logic commit_err;

    assign flush_eff = (HAS_FLUSH != 0) ? flush : '0;
    assign replay_en = (HAS_REPLAY != 0) && replay;
    assign commit_en = (HAS_REPLAY != 0) && commit;

    assign push_id_ok   = 32'(push_id) < C;
    assign pop_id_ok    = 32'(pop_id) < C;
    assign commit_id_ok = 32'(commit_id) < C;
    assign replay_id_ok = 32'(replay_id) < C;

    // Flush and a same-channel replay silently swallow requests; only real blockages raise err_r.
    assign push_flushed   = push_id_ok && flush_eff[push_id];
    assign pop_blocked    = pop_id_ok && (flush_eff[pop_id] || (replay_en && replay_id == pop_id));
    assign commit_flushed = commit_id_ok && flush_eff[commit_id];

    assign push_ok   = push && push_id_ok && !push_flushed && !full_r[push_id];
    assign pop_ok    = pop && pop_id_ok && !pop_blocked && !empty_r[pop_id];
    assign commit_ok = commit_en && commit_id_ok && !commit_flushed
                    && (arch_rptr_reg[commit_id] != spec_rptr_reg[commit_id]);

    assign push_err   = push && !push_flushed && (!push_id_ok || full_r[push_id]);
    assign pop_err    = pop && !pop_blocked && (!pop_id_ok || empty_r[pop_id]);
    assign commit_err = commit_en && !commit_flushed
                     && (!commit_id_ok || (arch_rptr_reg[commit_id] == spec_rptr_reg[commit_id]));

    generate
        for (genvar gi = 0; gi < C; gi++) begin : gen_ch
            assign push_hit[gi]   = push_ok && (push_id == IDW'(gi));
            assign pop_hit[gi]    = pop_ok && (pop_id == IDW'(gi));
            assign commit_hit[gi] = commit_ok && (commit_id == IDW'(gi));
            assign replay_hit[gi] = replay_en && replay_id_ok && (replay_id == IDW'(gi));

            assign arch_inc[gi] = arch_rptr_reg[gi] + ptr_t'(commit_hit[gi]);
            assign spec_adv[gi] = spec_rptr_reg[gi] + ptr_t'(pop_hit[gi]);

            assign wptr_next[gi] = flush_eff[gi] ? '0 : wptr_reg[gi] + ptr_t'(push_hit[gi]);
            // Without replay the architectural pointer simply tracks the read pointer.
            assign arch_rptr_next[gi] = flush_eff[gi] ? '0 :
                                        (HAS_REPLAY != 0) ? arch_inc[gi] : spec_adv[gi];
            // Replay lands on the post-commit arch pointer so a same-cycle commit stays retired.
            assign spec_rptr_next[gi] = flush_eff[gi] ? '0 :
                                        replay_hit[gi] ? arch_inc[gi] : spec_adv[gi];

            assign empty_next[gi] = spec_rptr_next[gi] == wptr_next[gi];
            assign full_next[gi]  = (wptr_next[gi] ^ arch_rptr_next[gi]) == {1'b1, {AW{1'b0}}};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[push_id][wptr_reg[push_id][AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < C; c++) begin
                wptr_reg[c]      <= '0;
                arch_rptr_reg[c] <= '0;
                spec_rptr_reg[c] <= '0;
            end
            empty_r    <= '1;
            full_r     <= '0;
            pop_vld_r  <= 1'b0;
            pop_data_r <= '0;
            err_r      <= 1'b0;
        end else begin
            for (int c = 0; c < C; c++) begin
                wptr_reg[c]      <= wptr_next[c];
                arch_rptr_reg[c] <= arch_rptr_next[c];
                spec_rptr_reg[c] <= spec_rptr_next[c];
            end
            empty_r   <= empty_next;
            full_r    <= full_next;
            pop_vld_r <= pop_ok;
            if (pop_ok) begin
                pop_data_r <= mem[pop_id][spec_rptr_reg[pop_id][AW-1:0]];
            end
            err_r <= push_err || pop_err || commit_err;
        end
    end

endmodule

// File: tb/tb_fifo_ptr_mc.sv
// Directed bench for fifo_ptr_mc (C=4, N=4, replay and flush enabled).
module tb_fifo_ptr_mc;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int C   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           push;
    logic [IDW-1:0] push_id;
    logic [W-1:0]   push_data;
    logic           pop;
    logic [IDW-1:0] pop_id;
    logic           pop_vld_r;
    logic [W-1:0]   pop_data_r;
    logic           commit;
    logic [IDW-1:0] commit_id;
    logic           replay;
    logic [IDW-1:0] replay_id;
    logic [C-1:0]   flush;
    logic [C-1:0]   empty_r;
    logic [C-1:0]   full_r;
    logic           err_r;

    int check_cnt = 0;
    int error_cnt = 0;

    always #5 clk = ~clk;

    fifo_ptr_mc #(
        .W(W), .N(N), .C(C), .HAS_REPLAY(1), .HAS_FLUSH(1)
    ) dut (
        .clk(clk), .rst(rst),
        .push(push), .push_id(push_id), .push_data(push_data),
        .pop(pop), .pop_id(pop_id), .pop_vld_r(pop_vld_r), .pop_data_r(pop_data_r),
        .commit(commit), .commit_id(commit_id),
        .replay(replay), .replay_id(replay_id),
        .flush(flush), .empty_r(empty_r), .full_r(full_r), .err_r(err_r)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic idle();
        push = 1'b0; pop = 1'b0; commit = 1'b0; replay = 1'b0; flush = '0;
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_push(input int id, input logic [W-1:0] d);
        push = 1'b1; push_id = IDW'(id); push_data = d;
        step();
    endtask

    task automatic do_pop(input string tag, input int id, input logic [W-1:0] exp);
        pop = 1'b1; pop_id = IDW'(id);
        step();
        check({tag, " vld"}, 32'(pop_vld_r), 32'd1);
        check({tag, " data"}, 32'(pop_data_r), 32'(exp));
    endtask

    task automatic do_commit(input int id);
        commit = 1'b1; commit_id = IDW'(id);
        step();
    endtask

    task automatic do_replay(input int id);
        replay = 1'b1; replay_id = IDW'(id);
        step();
    endtask

    initial begin
        idle();
        push_id = '0; push_data = '0; pop_id = '0; commit_id = '0; replay_id = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst empty", 32'(empty_r), 32'hF);
        check("rst full", 32'(full_r), 32'h0);
        check("rst vld", 32'(pop_vld_r), 32'h0);
        check("rst data", 32'(pop_data_r), 32'h0);
        check("rst err", 32'(err_r), 32'h0);

        // Fill channel 2, then overflow it.
        for (int i = 0; i < 4; i++) begin
            do_push(2, W'(8'hA0 + i));
            check("t1 push err", 32'(err_r), 32'h0);
        end
        check("t1 full", 32'(full_r), 32'b0100);
        check("t1 empty", 32'(empty_r), 32'b1011);
        do_push(2, 8'hA4);
        check("t1 ovf err", 32'(err_r), 32'h1);
        check("t1 ovf full", 32'(full_r), 32'b0100);
        step();
        check("t1 err pulse", 32'(err_r), 32'h0);

        // Drain channel 2, underflow it, then retire the popped entries.
        for (int i = 0; i < 4; i++) begin
            do_pop("t2 pop", 2, W'(8'hA0 + i));
        end
        check("t2 empty", 32'(empty_r), 32'hF);
        pop = 1'b1; pop_id = 2'd2;
        step();
        check("t2 udf err", 32'(err_r), 32'h1);
        check("t2 udf vld", 32'(pop_vld_r), 32'h0);
        check("t2 udf hold", 32'(pop_data_r), 32'hA3);
        check("t2 full uncommitted", 32'(full_r), 32'b0100);
        for (int i = 0; i < 4; i++) begin
            do_commit(2);
            check("t2 commit err", 32'(err_r), 32'h0);
        end
        check("t2 full after commit", 32'(full_r), 32'h0);
        do_commit(2);
        check("t2 bad commit err", 32'(err_r), 32'h1);

        // Replay on channel 1.
        do_push(1, 8'hB0);
        do_push(1, 8'hB1);
        do_push(1, 8'hB2);
        do_pop("t3 pop", 1, 8'hB0);
        do_pop("t3 pop", 1, 8'hB1);
        do_replay(1);
        check("t3 replay err", 32'(err_r), 32'h0);
        do_pop("t3 rpop0", 1, 8'hB0);
        do_pop("t3 rpop1", 1, 8'hB1);
        do_pop("t3 rpop2", 1, 8'hB2);
        check("t3 empty1", 32'(empty_r[1]), 32'h1);
        do_commit(1);
        do_replay(1);
        do_pop("t3 after commit", 1, 8'hB1);
        commit = 1'b1; commit_id = 2'd1; replay = 1'b1; replay_id = 2'd1;
        step();
        check("t3 rep+com err", 32'(err_r), 32'h0);
        do_pop("t3 rep+com pop", 1, 8'hB2);
        pop = 1'b1; pop_id = 2'd1; replay = 1'b1; replay_id = 2'd1;
        step();
        check("t3 rep+pop vld", 32'(pop_vld_r), 32'h0);
        check("t3 rep+pop err", 32'(err_r), 32'h0);
        do_pop("t3 rep+pop repop", 1, 8'hB2);
        do_commit(1);
        check("t3 final commit err", 32'(err_r), 32'h0);

        // Wrap channel 0 through ten push/pop/commit rounds with three entries preloaded.
        do_push(0, 8'h10);
        do_push(0, 8'h11);
        do_push(0, 8'h12);
        check("t4 pre full", 32'(full_r[0]), 32'h0);
        for (int i = 0; i < 10; i++) begin
            do_push(0, W'(8'h13 + i));
            check("t4 full at 4", 32'(full_r[0]), 32'h1);
            do_pop("t4 pop", 0, W'(8'h10 + i));
            check("t4 full uncommitted", 32'(full_r[0]), 32'h1);
            do_commit(0);
            check("t4 full after commit", 32'(full_r[0]), 32'h0);
        end

        // Flush ch3 alongside a push to ch3 and a pop from ch0.
        do_push(3, 8'hC0);
        check("t5 ch3 not empty", 32'(empty_r[3]), 32'h0);
        flush = 4'b1000;
        push = 1'b1; push_id = 2'd3; push_data = 8'hC1;
        pop = 1'b1; pop_id = 2'd0;
        step();
        check("t5 err", 32'(err_r), 32'h0);
        check("t5 vld", 32'(pop_vld_r), 32'h1);
        check("t5 data", 32'(pop_data_r), 32'h1A);
        check("t5 empty", 32'(empty_r), 32'b1110);
        check("t5 full", 32'(full_r), 32'h0);
        pop = 1'b1; pop_id = 2'd3;
        step();
        check("t5 ch3 pop err", 32'(err_r), 32'h1);
        check("t5 ch3 pop vld", 32'(pop_vld_r), 32'h0);

        // Reset right after a pop cancels everything.
        do_pop("t6 pop", 0, 8'h1B);
        rst = 1'b1;
        pop = 1'b1; pop_id = 2'd0;
        step();
        rst = 1'b0;
        check("t6 vld", 32'(pop_vld_r), 32'h0);
        check("t6 empty", 32'(empty_r), 32'hF);
        check("t6 full", 32'(full_r), 32'h0);
        check("t6 data", 32'(pop_data_r), 32'h0);
        check("t6 err", 32'(err_r), 32'h0);
        do_push(0, 8'h55);
        do_pop("t6 post pop", 0, 8'h55);

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
